// File: rtl/fir_coeff_ctrl.sv
// Double-buffered coefficient controller for a symmetric FIR: shadow/active banks, swap FSM, output masking.
// Optional feature: define FIR_CTRL_READBACK_EN to add a registered active-bank read port (cfg_rd_addr/cfg_rd_data).
module fir_coeff_ctrl #(
  parameter int DW      = 18,
  parameter int N_UNIQ  = 9,
  parameter int AW      = 4,
  parameter int FLUSH_N = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_wr_valid,
  output logic                 cfg_wr_ready,
  input  logic [AW-1:0]        cfg_wr_addr,
  input  logic [DW-1:0]        cfg_wr_data,
  input  logic                 cfg_commit,
  output logic                 cfg_busy,
  output logic                 cfg_err,
`ifdef FIR_CTRL_READBACK_EN
  input  logic [AW-1:0]        cfg_rd_addr,
  output logic [DW-1:0]        cfg_rd_data,
`endif
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DW-1:0]        s_data,
  output logic                 fir_clk_ena,
  output logic                 fir_i_valid,
  output logic [DW-1:0]        fir_i_in,
  input  logic                 fir_o_valid,
  input  logic [DW-1:0]        fir_o_out,
  output logic                 m_valid,
  output logic [DW-1:0]        m_data,
  output logic [N_UNIQ*DW-1:0] coeff_flat
);

  localparam int            CW         = (FLUSH_N < 1) ? 1 : $clog2(FLUSH_N + 1);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWAP  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          cfg_err_reg, cfg_err_next;
  logic          m_valid_reg;
  logic [DW-1:0] m_data_reg;

  logic wr_fire;
  logic wr_in_range;
  logic in_swap;
  logic mask_active;
  logic pass_pulse;

  assign in_swap     = (state_reg == SWAP);
  assign wr_fire     = cfg_wr_valid && cfg_wr_ready;
  assign wr_in_range = (32'(cfg_wr_addr) < N_UNIQ);
  // A zero count in FLUSH means nothing is left to hide (also the FLUSH_N=0 pass-through case).
  assign mask_active = (state_reg == FLUSH) && (cnt_reg != '0);
  assign pass_pulse  = fir_o_valid && !mask_active;

  assign cfg_wr_ready = !in_swap;
  assign s_ready      = !in_swap;
  assign cfg_busy     = (state_reg != IDLE);
  assign cfg_err      = cfg_err_reg;
  assign fir_i_valid  = s_valid && s_ready;
  assign fir_clk_ena  = s_valid && s_ready;
  assign fir_i_in     = s_data;
  assign m_valid      = m_valid_reg;
  assign m_data       = m_data_reg;

  generate
    for (genvar gi = 0; gi < N_UNIQ; gi++) begin : g_bank
      logic [DW-1:0] shadow_reg;
      logic [DW-1:0] active_reg;
      logic          wr_hit;

      assign wr_hit = wr_fire && (cfg_wr_addr == AW'(gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          shadow_reg <= '0;
          active_reg <= '0;
        end else begin
          if (wr_hit) begin
            shadow_reg <= cfg_wr_data;
          end
          if (in_swap) begin
            active_reg <= shadow_reg;
          end
        end
      end

      assign coeff_flat[gi*DW +: DW] = active_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      cfg_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      cfg_err_reg <= cfg_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cfg_err_next = cfg_err_reg;

    if (wr_fire && !wr_in_range) begin
      cfg_err_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (cfg_commit) begin
          state_next = SWAP;
        end
      end
      SWAP: begin
        state_next   = FLUSH;
        cnt_next     = FLUSH_LOAD;
        cfg_err_next = 1'b0;
      end
      FLUSH: begin
        if (mask_active && fir_o_valid) begin
          cnt_next = cnt_reg - CW'(1);
        end
        // Leave as soon as the last masked pulse has been consumed.
        if ((cnt_reg == '0) || ((cnt_reg == CW'(1)) && fir_o_valid)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
    end else begin
      m_valid_reg <= pass_pulse;
      if (pass_pulse) begin
        m_data_reg <= fir_o_out;
      end
    end
  end

`ifdef FIR_CTRL_READBACK_EN
  logic [DW-1:0] rd_mux;
  logic [DW-1:0] rd_data_reg;

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < N_UNIQ; k++) begin
      if (cfg_rd_addr == AW'(k)) begin
        rd_mux = coeff_flat[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= rd_mux;
    end
  end

  assign cfg_rd_data = rd_data_reg;
`endif

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Randomized self-checking bench for fir_coeff_ctrl against a bank/flush reference model.
// Define FIR_CTRL_READBACK_EN to also exercise the readback port.
module tb_fir_coeff_ctrl;
  localparam int DW      = 18;
  localparam int N_UNIQ  = 9;
  localparam int AW      = 4;
  localparam int FLUSH_N = 17;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 cfg_wr_valid = 1'b0;
  logic                 cfg_wr_ready;
  logic [AW-1:0]        cfg_wr_addr = '0;
  logic [DW-1:0]        cfg_wr_data = '0;
  logic                 cfg_commit = 1'b0;
  logic                 cfg_busy;
  logic                 cfg_err;
`ifdef FIR_CTRL_READBACK_EN
  logic [AW-1:0]        cfg_rd_addr = '0;
  logic [DW-1:0]        cfg_rd_data;
`endif
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [DW-1:0]        s_data = '0;
  logic                 fir_clk_ena;
  logic                 fir_i_valid;
  logic [DW-1:0]        fir_i_in;
  logic                 fir_o_valid = 1'b0;
  logic [DW-1:0]        fir_o_out = '0;
  logic                 m_valid;
  logic [DW-1:0]        m_data;
  logic [N_UNIQ*DW-1:0] coeff_flat;

  always #5 clk = ~clk;

  fir_coeff_ctrl #(.DW(DW), .N_UNIQ(N_UNIQ), .AW(AW), .FLUSH_N(FLUSH_N)) dut (
    .clk(clk), .reset(reset),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
`ifdef FIR_CTRL_READBACK_EN
    .cfg_rd_addr(cfg_rd_addr), .cfg_rd_data(cfg_rd_data),
`endif
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fir_clk_ena(fir_clk_ena), .fir_i_valid(fir_i_valid), .fir_i_in(fir_i_in),
    .fir_o_valid(fir_o_valid), .fir_o_out(fir_o_out),
    .m_valid(m_valid), .m_data(m_data), .coeff_flat(coeff_flat)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: banks as plain arrays, plus how many output pulses are still to be hidden.
  logic [DW-1:0] shadow_m [N_UNIQ];
  logic [DW-1:0] active_m [N_UNIQ];
  logic [DW-1:0] last_m;
  bit            err_m;
  bit            busy_m;
  int            masked_left;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_UNIQ; k++) begin
      shadow_m[k] = '0;
      active_m[k] = '0;
    end
    last_m      = '0;
    err_m       = 1'b0;
    busy_m      = 1'b0;
    masked_left = 0;
  endtask

  task automatic check_bank(input string tag);
    for (int k = 0; k < N_UNIQ; k++) begin
      check($sformatf("%s_coeff%0d", tag, k), coeff_flat[k*DW +: DW], active_m[k]);
    end
  endtask

  task automatic wr(input int addr, input logic [DW-1:0] d);
    check("wr_ready", cfg_wr_ready, 1'b1);
    cfg_wr_valid = 1'b1;
    cfg_wr_addr  = AW'(addr);
    cfg_wr_data  = d;
    tick();
    cfg_wr_valid = 1'b0;
    if (addr < N_UNIQ) shadow_m[addr] = d;
    else err_m = 1'b1;
    check("wr_err", cfg_err, err_m);
    $display("wr   addr=%0d data=%0h err=%0b", addr, d, cfg_err);
  endtask

  task automatic commit(input string tag);
    bit acc;
    acc = !busy_m;
    cfg_commit = 1'b1;
    tick();
    cfg_commit   = 1'b0;
    cfg_wr_valid = 1'b0;
    if (acc) begin
      check({tag, "_swap_busy"}, cfg_busy, 1'b1);
      check({tag, "_swap_s_ready"}, s_ready, 1'b0);
      check({tag, "_swap_wr_ready"}, cfg_wr_ready, 1'b0);
      tick();
      for (int k = 0; k < N_UNIQ; k++) active_m[k] = shadow_m[k];
      err_m       = 1'b0;
      masked_left = FLUSH_N;
      busy_m      = (FLUSH_N > 0);
    end else begin
      tick();
    end
    check_bank(tag);
    check({tag, "_err"}, cfg_err, err_m);
    check({tag, "_busy"}, cfg_busy, busy_m);
    $display("cmt  %s accepted=%0b busy=%0b", tag, acc, cfg_busy);
  endtask

  task automatic pulse(output bit seen);
    logic [DW-1:0] d;
    bit            pass;
    int            gap;
    d    = DW'($urandom());
    pass = (masked_left == 0);
    check("pulse_busy_pre", cfg_busy, busy_m);
    fir_o_valid = 1'b1;
    fir_o_out   = d;
    tick();
    fir_o_valid = 1'b0;
    if (pass) begin
      last_m = d;
    end else begin
      masked_left--;
      if (masked_left == 0) busy_m = 1'b0;
    end
    seen = m_valid;
    check("pulse_m_valid", m_valid, pass);
    if (pass) check("pulse_m_data", m_data, d);
    check("pulse_busy_post", cfg_busy, busy_m);
    $display("pls  data=%0h m_valid=%0b busy=%0b", d, m_valid, cfg_busy);
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      tick();
      check("gap_m_valid", m_valid, 1'b0);
      if (pass) check("gap_m_data_hold", m_data, d);
    end
  endtask

  task automatic drain();
    bit seen;
    for (int i = 0; i < 4 * FLUSH_N + 4 && busy_m; i++) pulse(seen);
    check("drain_idle", cfg_busy, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check({tag, "_busy"}, cfg_busy, 1'b0);
    check({tag, "_m_valid"}, m_valid, 1'b0);
    check({tag, "_m_data"}, m_data, '0);
    check({tag, "_err"}, cfg_err, 1'b0);
    check_bank(tag);
    tick();
    reset = 1'b0;
    $display("rst  %s", tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit            seen;
    int            n_pass;
    logic [DW-1:0] sent [$];
    logic [DW-1:0] recv [$];
    int            idx;
    int            low_cycles;

    model_reset();
    repeat (3) tick();
    check("rst_busy", cfg_busy, 1'b0);
    check("rst_err", cfg_err, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, '0);
    check("rst_wr_ready", cfg_wr_ready, 1'b1);
    check("rst_s_ready", s_ready, 1'b1);
    check_bank("rst");
    reset = 1'b0;
    tick();

    // Ramp bank; the final write lands in the same cycle as the commit.
    for (int k = 0; k < N_UNIQ - 1; k++) wr(k, DW'(k + 1));
    cfg_wr_valid = 1'b1;
    cfg_wr_addr  = AW'(N_UNIQ - 1);
    cfg_wr_data  = DW'(N_UNIQ);
    shadow_m[N_UNIQ-1] = DW'(N_UNIQ);
    commit("ramp");
`ifdef FIR_CTRL_READBACK_EN
    cfg_rd_addr = AW'(3);
    tick();
    check("rd_addr3", cfg_rd_data, DW'(4));
    cfg_rd_addr = AW'(12);
    tick();
    check("rd_addr12", cfg_rd_data, '0);
`endif
    n_pass = 0;
    for (int i = 0; i < 20; i++) begin
      pulse(seen);
      if (seen) n_pass++;
    end
    check("ramp_pass_cnt", n_pass, 20 - FLUSH_N);
    check("ramp_idle", cfg_busy, 1'b0);

    // Random writes including out-of-range addresses.
    wr(12, DW'($urandom()));
    check_bank("oor");
    for (int i = 0; i < 12; i++) wr($urandom_range(0, 15), DW'($urandom()));
    commit("rand");
    drain();

    // Continuous stream across a commit.
    for (int i = 0; i < 40; i++) sent.push_back(DW'($urandom()));
    idx = 0;
    low_cycles = 0;
    s_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      s_data     = sent[idx];
      cfg_commit = (c == 10);
      #3;
      if (fir_i_valid) recv.push_back(fir_i_in);
      if (!s_ready) low_cycles++;
      if (s_valid && s_ready) idx++;
      tick();
    end
    s_valid    = 1'b0;
    cfg_commit = 1'b0;
    for (int k = 0; k < N_UNIQ; k++) active_m[k] = shadow_m[k];
    err_m = 1'b0;
    masked_left = FLUSH_N;
    busy_m = 1'b1;
    check("stream_low_cycles", low_cycles, 1);
    check("stream_count", recv.size(), idx);
    check("stream_total", recv.size(), 29);
    for (int k = 0; k < recv.size(); k++) check($sformatf("stream_s%0d", k), recv[k], sent[k]);
    $display("strm sent=%0d recv=%0d low=%0d", idx, recv.size(), low_cycles);
    check_bank("stream");
    drain();

    // Commit during FLUSH must be ignored and not queued.
    wr(2, DW'($urandom()));
    commit("flush_a");
    for (int i = 0; i < 5; i++) pulse(seen);
    wr(0, DW'($urandom()));
    commit("ignored");
    drain();
    repeat (3) tick();
    check("no_queue_busy", cfg_busy, 1'b0);
    check_bank("no_queue");

    // Reset mid-FLUSH with cfg_err set.
    commit("flush_b");
    for (int i = 0; i < 3; i++) pulse(seen);
    wr(14, DW'($urandom()));
    async_reset("rst_flush");

    // Reset mid-SWAP: no partial copy may survive.
    for (int k = 0; k < N_UNIQ; k++) wr(k, DW'($urandom_range(1, 1000)));
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    async_reset("rst_swap");
    commit("post_rst");
    drain();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
